// File: rtl/iob_rom_stream_if.sv
// Bundles the ROM read port and the outgoing valid/ready stream of iob_rom_stream.
// The master side is the streamer; the slave side is the ROM plus stream sink.
interface iob_rom_stream_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11
);
   logic              rom_r_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_r_data;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;

   modport master (
      output rom_r_en, rom_addr, m_data, m_valid,
      input  rom_r_data, m_ready
   );

   modport slave (
      input  rom_r_en, rom_addr, m_data, m_valid,
      output rom_r_data, m_ready
   );
endinterface

// File: rtl/iob_rom_stream.sv
// Burst reader: streams len consecutive ROM words from start_addr over valid/ready,
// using a 2-entry buffer plus credit check to cover the ROM's 1-cycle read latency.
module iob_rom_stream #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   iob_rom_stream_if.master  bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   logic [1:0]        state;
   logic [ADDR_W:0]   remaining;
   logic [ADDR_W-1:0] next_addr;
   logic [ADDR_W-1:0] last_addr;
   logic              rd_pending;
   logic [DATA_W-1:0] fifo_mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_count;
   logic              pop;
   logic              push;
   logic              issue;
   logic [2:0]        credit;

   // A read issued now lands in the buffer one cycle later, so count words
   // already buffered plus the one in flight, minus the one leaving this cycle.
   assign pop    = (fifo_count != 2'd0) && bus.m_ready;
   assign push   = rd_pending;
   assign credit = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, pop};
   assign issue  = (state == ST_RUN) && (remaining != '0) && (credit < 3'd2);

   assign bus.rom_r_en = issue;
   assign bus.rom_addr = issue ? next_addr : last_addr;
   assign bus.m_valid  = (fifo_count != 2'd0);
   assign bus.m_data   = fifo_mem[rd_ptr];
   assign busy         = (state != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         remaining <= '0;
         next_addr <= '0;
         last_addr <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     state     <= ST_RUN;
                     remaining <= len;
                     next_addr <= start_addr;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (issue) begin
                  remaining <= remaining - LEN_ONE;
                  next_addr <= next_addr + ADDR_ONE;
                  last_addr <= next_addr;
                  if (remaining == LEN_ONE) begin
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // Last word leaves when nothing is in flight and only one word remains.
               if (pop && (fifo_count == 2'd1) && !rd_pending) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pending <= 1'b0;
      end else begin
         rd_pending <= issue;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_count  <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= bus.rom_r_data;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_iob_rom_stream.sv
// Bench for iob_rom_stream: a queue-based model of expected addresses and words,
// directed bursts for timing/wrap/reset cases, then randomized bursts and backpressure.
module tb_iob_rom_stream;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W:0]   len;
   logic              busy;
   logic              done;

   iob_rom_stream_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   iob_rom_stream #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .bus        (bus)
   );

   logic [DATA_W-1:0] rom_mem [DEPTH];
   logic [DATA_W-1:0] exp_data [$];
   logic [ADDR_W-1:0] exp_addr [$];
   int                hs_cyc [$];
   int                rd_cyc [$];
   int                done_cycs [$];
   int                busy_cnt;
   int                cyc;
   int                num_tests;
   int                num_fail;
   int                ready_mode;
   int                ready_phase;
   logic              prev_stall;
   logic [DATA_W-1:0] prev_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      for (int i = 0; i < DEPTH; i++) rom_mem[i] = 32'h100 + 32'(i);
   end

   // Registered-read ROM, as on iob_rom_sp
   always @(posedge clk) begin
      if (bus.rom_r_en) bus.rom_r_data <= rom_mem[bus.rom_addr];
   end

   initial begin
      ready_phase = 0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: bus.m_ready = 1'b1;
            1: begin
               bus.m_ready = (ready_phase == 0);
               ready_phase = (ready_phase == 2) ? 0 : ready_phase + 1;
            end
            default: bus.m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      num_tests++;
      if (obs !== exp) begin
         num_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (busy) busy_cnt++;
            if (done) done_cycs.push_back(cyc);
            if (bus.rom_r_en) begin
               rd_cyc.push_back(cyc);
               checkOutput("read_expected", 32'(exp_addr.size() != 0), 32'd1);
               if (exp_addr.size() != 0) checkOutput("rom_addr", 32'(bus.rom_addr), 32'(exp_addr.pop_front()));
            end
            if (prev_stall) begin
               checkOutput("stall_valid", 32'(bus.m_valid), 32'd1);
               checkOutput("stall_data", bus.m_data, prev_data);
            end
            if (bus.m_valid && bus.m_ready) begin
               hs_cyc.push_back(cyc);
               checkOutput("word_expected", 32'(exp_data.size() != 0), 32'd1);
               if (exp_data.size() != 0) checkOutput("m_data", bus.m_data, exp_data.pop_front());
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
         end
      end
   end

   task automatic clearObs();
      hs_cyc.delete();
      rd_cyc.delete();
      done_cycs.delete();
      busy_cnt = 0;
   endtask

   task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [ADDR_W:0] n,
                                input bit accept, input bit immediate, output int c0);
      logic [ADDR_W-1:0] a;
      if (!immediate) @(negedge clk);
      start      = 1'b1;
      start_addr = addr;
      len        = n;
      c0         = cyc;
      if (accept) begin
         for (int i = 0; i < int'(n); i++) begin
            a = addr + ADDR_W'(i);
            exp_addr.push_back(a);
            exp_data.push_back(rom_mem[a]);
         end
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone(input int bound);
      bit found;
      found = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (done) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!found) checkOutput("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_rom_r_en"}, 32'(bus.rom_r_en), 32'd0);
      checkOutput({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
      checkOutput({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
      checkOutput({tag, "_m_data"}, bus.m_data, 32'd0);
   endtask

   task automatic checkBurstEnd(input string tag, input int words);
      checkOutput({tag, "_words"}, 32'(hs_cyc.size()), 32'(words));
      checkOutput({tag, "_reads"}, 32'(rd_cyc.size()), 32'(words));
      checkOutput({tag, "_done_count"}, 32'(done_cycs.size()), 32'd1);
      checkOutput({tag, "_data_left"}, 32'(exp_data.size()), 32'd0);
      checkOutput({tag, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
   endtask

   initial begin
      int c0;
      int c1;
      int n;
      num_tests  = 0;
      num_fail   = 0;
      ready_mode = 0;
      busy_cnt   = 0;
      rst        = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      len        = '0;
      repeat (2) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Unstalled burst: exact cycle timing of reads, words and done
      ready_mode = 0;
      clearObs();
      applyStimulus(5'h10, 6'd4, 1'b1, 1'b0, c0);
      waitDone(200);
      #1;
      checkBurstEnd("t1", 4);
      for (int i = 0; i < 4; i++) begin
         if (i < rd_cyc.size()) checkOutput("t1_read_cycle", 32'(rd_cyc[i] - c0), 32'(1 + i));
         if (i < hs_cyc.size()) checkOutput("t1_word_cycle", 32'(hs_cyc[i] - c0), 32'(3 + i));
      end
      if (done_cycs.size() != 0) checkOutput("t1_done_cycle", 32'(done_cycs[0] - c0), 32'd7);

      // Backpressure 1,0,0 pattern
      ready_mode = 1;
      clearObs();
      applyStimulus(5'h10, 6'd4, 1'b1, 1'b0, c0);
      waitDone(200);
      #1;
      checkBurstEnd("t2", 4);

      // Address wrap at top of ROM
      ready_mode = 2;
      clearObs();
      applyStimulus(5'h1E, 6'd4, 1'b1, 1'b0, c0);
      waitDone(200);
      #1;
      checkBurstEnd("t3", 4);

      // Zero-length request
      ready_mode = 0;
      clearObs();
      applyStimulus(5'h03, 6'd0, 1'b1, 1'b0, c0);
      waitDone(20);
      #1;
      repeat (4) @(negedge clk);
      #1;
      checkOutput("t4_done_count", 32'(done_cycs.size()), 32'd1);
      if (done_cycs.size() != 0) checkOutput("t4_done_cycle", 32'(done_cycs[0] - c0), 32'd1);
      checkOutput("t4_reads", 32'(rd_cyc.size()), 32'd0);
      checkOutput("t4_words", 32'(hs_cyc.size()), 32'd0);
      checkOutput("t4_busy_cycles", 32'(busy_cnt), 32'd0);

      // Start while busy is ignored
      ready_mode = 1;
      clearObs();
      applyStimulus(5'h04, 6'd8, 1'b1, 1'b0, c0);
      applyStimulus(5'h15, 6'd5, 1'b0, 1'b0, c1);
      waitDone(400);
      #1;
      checkBurstEnd("t5", 8);

      // New start accepted in the done cycle
      ready_mode = 0;
      clearObs();
      applyStimulus(5'h02, 6'd3, 1'b1, 1'b0, c0);
      waitDone(200);
      applyStimulus(5'h09, 6'd2, 1'b1, 1'b1, c1);
      waitDone(200);
      #1;
      checkOutput("chain_words", 32'(hs_cyc.size()), 32'd5);
      checkOutput("chain_done_count", 32'(done_cycs.size()), 32'd2);
      checkOutput("chain_data_left", 32'(exp_data.size()), 32'd0);

      // Whole ROM in one burst
      ready_mode = 2;
      clearObs();
      applyStimulus(5'h07, 6'd32, 1'b1, 1'b0, c0);
      waitDone(1000);
      #1;
      checkBurstEnd("full", 32);

      // Mid-burst reset, then a fresh short burst
      ready_mode = 0;
      clearObs();
      applyStimulus(5'h00, 6'd8, 1'b1, 1'b0, c0);
      for (int i = 0; i < 50; i++) begin
         if (hs_cyc.size() >= 2) break;
         @(negedge clk);
         #1;
      end
      checkOutput("t6_words_before_reset", 32'(hs_cyc.size()), 32'd2);
      #1;
      rst = 1'b1;
      #1;
      checkResetOutputs("t6_reset");
      exp_data.delete();
      exp_addr.delete();
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      clearObs();
      applyStimulus(5'h00, 6'd2, 1'b1, 1'b0, c0);
      waitDone(200);
      #1;
      checkBurstEnd("t6", 2);

      // Randomized bursts and backpressure
      for (int k = 0; k < 15; k++) begin
         ready_mode = int'($urandom_range(0, 2));
         n = int'($urandom_range(0, DEPTH));
         clearObs();
         applyStimulus(ADDR_W'($urandom), 6'(n), 1'b1, 1'b0, c0);
         waitDone(2000);
         #1;
         checkBurstEnd("rand", n);
      end

      $display("[TB] %0d tests run, %0d failed", num_tests, num_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
